// File: rtl/tcm_dport_arb.sv
// Round-robin arbiter merging the core and loader data ports onto one TCM port.
// Responses are steered back in order using a small source-id FIFO.
module tcm_dport_arb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_wr_i,
    input  logic        c_rd_i,
    input  logic [3:0]  c_wr_i,
    input  logic [10:0] c_req_tag_i,
    output logic        c_accept_o,
    output logic        c_ack_o,
    output logic        c_error_o,
    output logic [31:0] c_data_rd_o,
    output logic [10:0] c_resp_tag_o,
    input  logic [31:0] l_addr_i,
    input  logic [31:0] l_data_wr_i,
    input  logic        l_rd_i,
    input  logic [3:0]  l_wr_i,
    output logic        l_accept_o,
    output logic        l_ack_o,
    output logic        l_error_o,
    output logic [31:0] l_data_rd_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_wr_o,
    output logic        m_rd_o,
    output logic [3:0]  m_wr_o,
    output logic [10:0] m_req_tag_o,
    input  logic        m_accept_i,
    input  logic        m_ack_i,
    input  logic        m_error_i,
    input  logic [31:0] m_data_rd_i,
    input  logic [10:0] m_resp_tag_i,
    output logic        spurious_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] r_src;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_hold;
    logic             r_hold_l;
    logic             r_last_l;
    logic             r_spur;

    logic       w_c_req;
    logic       w_l_req;
    logic       w_gnt_v;
    logic       w_gnt_l;
    logic       w_full;
    logic       w_empty;
    logic       w_fwd;
    logic       w_push;
    logic       w_pop;
    logic       w_head;
    logic       w_sel_rd;
    logic [3:0] w_sel_wr;

    assign w_c_req = c_rd_i | (|c_wr_i);
    assign w_l_req = l_rd_i | (|l_wr_i);

    // A request left waiting on the TCM keeps the grant until it is taken.
    always_comb begin
        w_gnt_v = 1'b0;
        w_gnt_l = 1'b0;
        if (r_hold && (r_hold_l ? w_l_req : w_c_req)) begin
            w_gnt_v = 1'b1;
            w_gnt_l = r_hold_l;
        end else if (w_c_req && w_l_req) begin
            w_gnt_v = 1'b1;
            w_gnt_l = ~r_last_l;
        end else if (w_c_req) begin
            w_gnt_v = 1'b1;
            w_gnt_l = 1'b0;
        end else if (w_l_req) begin
            w_gnt_v = 1'b1;
            w_gnt_l = 1'b1;
        end
    end

    assign w_full  = (r_count == FULL);
    assign w_empty = (r_count == '0);
    assign w_fwd   = w_gnt_v & ~w_full & rst;
    assign w_push  = w_fwd & m_accept_i;
    assign w_pop   = m_ack_i & ~w_empty;
    assign w_head  = r_src[r_rptr];

    assign w_sel_rd = w_gnt_l ? l_rd_i : c_rd_i;
    assign w_sel_wr = w_gnt_l ? l_wr_i : c_wr_i;

    // Write strobes dominate a simultaneous read strobe.
    assign m_wr_o      = w_fwd ? w_sel_wr : 4'h0;
    assign m_rd_o      = w_fwd & w_sel_rd & ~(|w_sel_wr);
    assign m_addr_o    = w_gnt_l ? l_addr_i : c_addr_i;
    assign m_data_wr_o = w_gnt_l ? l_data_wr_i : c_data_wr_i;
    assign m_req_tag_o = w_gnt_l ? 11'h000 : c_req_tag_i;

    assign c_accept_o = w_push & ~w_gnt_l;
    assign l_accept_o = w_push & w_gnt_l;

    assign c_ack_o      = w_pop & ~w_head;
    assign l_ack_o      = w_pop & w_head;
    assign c_error_o    = c_ack_o & m_error_i;
    assign l_error_o    = l_ack_o & m_error_i;
    assign c_data_rd_o  = m_data_rd_i;
    assign l_data_rd_o  = m_data_rd_i;
    assign c_resp_tag_o = m_resp_tag_i;
    assign spurious_o   = r_spur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_hold   <= 1'b0;
            r_hold_l <= 1'b0;
            r_last_l <= 1'b1;
            r_spur   <= 1'b0;
        end else begin
            r_hold   <= w_gnt_v & ~w_push;
            r_hold_l <= w_gnt_l;
            if (w_push) begin
                r_src[r_wptr] <= w_gnt_l;
                r_wptr        <= r_wptr + PW'(1);
                r_last_l      <= w_gnt_l;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (m_ack_i && w_empty) begin
                r_spur <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Directed, table-driven bench for tcm_dport_arb (DEPTH = 4).
module tb_tcm_dport_arb;

    localparam logic [31:0] CA = 32'h8000_9000;
    localparam logic [31:0] LA = 32'h0000_1000;
    localparam logic [31:0] CD = 32'hC0C0_C0C0;
    localparam logic [31:0] LD = 32'h1010_1010;

    logic        clk;
    logic        rst;
    logic [31:0] c_addr_i, c_data_wr_i, l_addr_i, l_data_wr_i;
    logic        c_rd_i, l_rd_i;
    logic [3:0]  c_wr_i, l_wr_i;
    logic [10:0] c_req_tag_i;
    logic        c_accept_o, c_ack_o, c_error_o;
    logic [31:0] c_data_rd_o;
    logic [10:0] c_resp_tag_o;
    logic        l_accept_o, l_ack_o, l_error_o;
    logic [31:0] l_data_rd_o;
    logic [31:0] m_addr_o, m_data_wr_o;
    logic        m_rd_o;
    logic [3:0]  m_wr_o;
    logic [10:0] m_req_tag_o;
    logic        m_accept_i, m_ack_i, m_error_i;
    logic [31:0] m_data_rd_i;
    logic [10:0] m_resp_tag_i;
    logic        spurious_o;

    int n_tot  = 0;
    int n_pass = 0;

    tcm_dport_arb #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .c_addr_i(c_addr_i), .c_data_wr_i(c_data_wr_i),
        .c_rd_i(c_rd_i), .c_wr_i(c_wr_i), .c_req_tag_i(c_req_tag_i),
        .c_accept_o(c_accept_o), .c_ack_o(c_ack_o), .c_error_o(c_error_o),
        .c_data_rd_o(c_data_rd_o), .c_resp_tag_o(c_resp_tag_o),
        .l_addr_i(l_addr_i), .l_data_wr_i(l_data_wr_i),
        .l_rd_i(l_rd_i), .l_wr_i(l_wr_i),
        .l_accept_o(l_accept_o), .l_ack_o(l_ack_o), .l_error_o(l_error_o),
        .l_data_rd_o(l_data_rd_o),
        .m_addr_o(m_addr_o), .m_data_wr_o(m_data_wr_o),
        .m_rd_o(m_rd_o), .m_wr_o(m_wr_o), .m_req_tag_o(m_req_tag_o),
        .m_accept_i(m_accept_i), .m_ack_i(m_ack_i), .m_error_i(m_error_i),
        .m_data_rd_i(m_data_rd_i), .m_resp_tag_i(m_resp_tag_i),
        .spurious_o(spurious_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          rs;
        bit          crd;
        logic [3:0]  cwr;
        logic [10:0] ctag;
        bit          lrd;
        logic [3:0]  lwr;
        bit          macc;
        bit          mack;
        logic [31:0] mdat;
        logic [10:0] mrtag;
        bit          e_cacc;
        bit          e_lacc;
        bit          e_mrd;
        logic [3:0]  e_mwr;
        logic [10:0] e_mtag;
        logic [31:0] e_madr;
        bit          e_cack;
        bit          e_lack;
        bit          e_spur;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic apply(input vec_t v, input string nm);
        if (v.rs) begin
            rst = 1'b0;
            #1;
            rst = 1'b1;
        end
        c_rd_i       = v.crd;
        c_wr_i       = v.cwr;
        c_req_tag_i  = v.ctag;
        l_rd_i       = v.lrd;
        l_wr_i       = v.lwr;
        m_accept_i   = v.macc;
        m_ack_i      = v.mack;
        m_data_rd_i  = v.mdat;
        m_resp_tag_i = v.mrtag;
        m_error_i    = v.mdat[0];
        #1;
        chk({nm, " c_acc"}, 32'(c_accept_o), 32'(v.e_cacc));
        chk({nm, " l_acc"}, 32'(l_accept_o), 32'(v.e_lacc));
        chk({nm, " m_rd"}, 32'(m_rd_o), 32'(v.e_mrd));
        chk({nm, " m_wr"}, 32'(m_wr_o), 32'(v.e_mwr));
        chk({nm, " c_ack"}, 32'(c_ack_o), 32'(v.e_cack));
        chk({nm, " l_ack"}, 32'(l_ack_o), 32'(v.e_lack));
        chk({nm, " spur"}, 32'(spurious_o), 32'(v.e_spur));
        chk({nm, " c_err"}, 32'(c_error_o), 32'(v.e_cack & v.mdat[0]));
        if (v.e_mrd || v.e_mwr != 4'h0) begin
            chk({nm, " m_addr"}, m_addr_o, v.e_madr);
            chk({nm, " m_tag"}, 32'(m_req_tag_o), 32'(v.e_mtag));
            chk({nm, " m_wdat"}, m_data_wr_o, (v.e_madr == CA) ? CD : LD);
        end
        if (v.e_cack) begin
            chk({nm, " c_rdat"}, c_data_rd_o, v.mdat);
            chk({nm, " c_rtag"}, 32'(c_resp_tag_o), 32'(v.mrtag));
        end
        if (v.e_lack) begin
            chk({nm, " l_rdat"}, l_data_rd_o, v.mdat);
            chk({nm, " l_err"}, 32'(l_error_o), 32'(v.mdat[0]));
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        // rs crd cwr ctag lrd lwr macc mack mdat mrtag | cacc lacc mrd mwr mtag madr cack lack spur
        // single core read, ack two cycles later
        tbl.push_back('{0,1,4'h0,11'h005,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h005,CA,0,0,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,0,32'h0,11'h0, 0,0,0,4'h0,11'h000,32'h0,0,0,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'hDEADBEEF,11'h005, 0,0,0,4'h0,11'h0,32'h0,1,0,0});
        // both ports continuously from reset: c, l, c, l
        tbl.push_back('{1,1,4'h0,11'h001,1,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h001,CA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h001,1,4'h0,1,0,32'h0,11'h0, 0,1,1,4'h0,11'h000,LA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h001,1,4'h0,1,1,32'h11111111,11'h001, 1,0,1,4'h0,11'h001,CA,1,0,0});
        tbl.push_back('{0,1,4'h0,11'h001,1,4'h0,1,1,32'h22222222,11'h000, 0,1,1,4'h0,11'h000,LA,0,1,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'h33333333,11'h001, 0,0,0,4'h0,11'h0,32'h0,1,0,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'h44444445,11'h000, 0,0,0,4'h0,11'h0,32'h0,0,1,0});
        // loader write stalled three cycles, core arrives during the stall
        tbl.push_back('{0,0,4'h0,11'h000,0,4'hF,0,0,32'h0,11'h0, 0,0,0,4'hF,11'h000,LA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h007,0,4'hF,0,0,32'h0,11'h0, 0,0,0,4'hF,11'h000,LA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h007,0,4'hF,0,0,32'h0,11'h0, 0,0,0,4'hF,11'h000,LA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h007,0,4'hF,1,0,32'h0,11'h0, 0,1,0,4'hF,11'h000,LA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h007,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h007,CA,0,0,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'hAAAA0000,11'h000, 0,0,0,4'h0,11'h0,32'h0,0,1,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'hBBBB0001,11'h007, 0,0,0,4'h0,11'h0,32'h0,1,0,0});
        // fill to DEPTH, fifth request blocked until a pop
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h002,CA,0,0,0});
        tbl.push_back('{0,1,4'h3,11'h002,0,4'h0,1,0,32'h0,11'h0, 1,0,0,4'h3,11'h002,CA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h002,CA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h002,CA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,0,32'h0,11'h0, 0,0,0,4'h0,11'h002,CA,0,0,0});
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,1,32'h55555555,11'h002, 0,0,0,4'h0,11'h002,CA,1,0,0});
        tbl.push_back('{0,1,4'h0,11'h002,0,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h002,CA,0,0,0});
        for (int k = 0; k < 4; k++)
            tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'h6000_0000 + 32'(k),11'h002,
                            0,0,0,4'h0,11'h0,32'h0,1,0,0});
        // ack with nothing outstanding, then reset clears the sticky flag
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,1,32'h77777777,11'h0, 0,0,0,4'h0,11'h0,32'h0,0,0,0});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,0,32'h0,11'h0, 0,0,0,4'h0,11'h0,32'h0,0,0,1});
        tbl.push_back('{0,0,4'h0,11'h000,0,4'h0,0,0,32'h0,11'h0, 0,0,0,4'h0,11'h0,32'h0,0,0,1});
        tbl.push_back('{1,0,4'h0,11'h000,0,4'h0,0,0,32'h0,11'h0, 0,0,0,4'h0,11'h0,32'h0,0,0,0});

        c_addr_i    = CA;
        c_data_wr_i = CD;
        l_addr_i    = LA;
        l_data_wr_i = LD;
        rst          = 1'b0;
        c_rd_i       = 1'b1;
        c_wr_i       = 4'h0;
        c_req_tag_i  = 11'h3;
        l_rd_i       = 1'b1;
        l_wr_i       = 4'h0;
        m_accept_i   = 1'b1;
        m_ack_i      = 1'b1;
        m_error_i    = 1'b0;
        m_data_rd_i  = 32'h0;
        m_resp_tag_i = 11'h0;

        // requests and acks presented while held in reset go nowhere
        @(posedge clk);
        #2;
        chk("rst c_acc", 32'(c_accept_o), 32'd0);
        chk("rst l_acc", 32'(l_accept_o), 32'd0);
        chk("rst c_ack", 32'(c_ack_o), 32'd0);
        chk("rst l_ack", 32'(l_ack_o), 32'd0);
        chk("rst m_rd", 32'(m_rd_o), 32'd0);
        @(posedge clk);
        #2;
        chk("rst spur", 32'(spurious_o), 32'd0);
        m_ack_i = 1'b0;
        m_accept_i = 1'b0;
        c_rd_i = 1'b0;
        l_rd_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // reset with three entries outstanding
        apply('{0,1,4'h0,11'h009,1,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h009,CA,0,0,0}, "h0");
        apply('{0,1,4'h0,11'h009,1,4'h0,1,0,32'h0,11'h0, 0,1,1,4'h0,11'h000,LA,0,0,0}, "h1");
        apply('{0,1,4'h0,11'h009,1,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h009,CA,0,0,0}, "h2");
        apply('{1,0,4'h0,11'h000,0,4'h0,0,1,32'h88888888,11'h0, 0,0,0,4'h0,11'h0,32'h0,0,0,0}, "h3");
        apply('{0,1,4'h0,11'h00A,1,4'h0,1,0,32'h0,11'h0, 1,0,1,4'h0,11'h00A,CA,0,0,1}, "h4");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
